// File: rtl/sine_request_sequencer.sv
// Front end for the sine/cosine LUT calculator: issues a cosine then a sine request per angle,
// tracks the fixed-latency calculator with a tag pipe and buffers {cos,sin,last} in a credit-protected FIFO.
module sine_request_sequencer #(
    parameter int  EXP_LEN      = 8,
    parameter int  MANTISSA_LEN = 23,
    parameter int  CALC_LATENCY = 2,
    parameter int  FIFO_DEPTH   = 4,
    localparam int W            = EXP_LEN + MANTISSA_LEN + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_theta,
    input  logic         in_last,
    output logic         calc_enable,
    output logic [W-1:0] calc_theta,
    output logic         calc_sine_cosine,
    input  logic [W-1:0] calc_value,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_cos,
    output logic [W-1:0] out_sin,
    output logic         out_last
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COS  = 2'd1,
        SIN  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  run_q;
    logic [W-1:0]          theta_q, theta_d;
    logic                  last_q, last_d;
    logic                  calc_en_q, calc_en_d;
    logic                  calc_sel_q, calc_sel_d;
    logic [CW-1:0]         pend_q, pend_d;
    logic [W-1:0]          cos_q, cos_d;
    logic [CALC_LATENCY:1] tag_vld_q, tag_vld_d;
    logic [CALC_LATENCY:1] tag_sel_q, tag_sel_d;
    logic [CALC_LATENCY:1] tag_last_q, tag_last_d;
    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [W-1:0]          mem_cos_q [FIFO_DEPTH];
    logic [W-1:0]          mem_cos_d [FIFO_DEPTH];
    logic [W-1:0]          mem_sin_q [FIFO_DEPTH];
    logic [W-1:0]          mem_sin_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_q, mem_last_d;

    logic [CW-1:0] fifo_count;
    logic [CW-1:0] occ;
    logic          credit;
    logic          accept;
    logic          push;
    logic          pop;

    // occ covers pairs already in the FIFO plus pairs still travelling through the calculator,
    // so a push can never land on a full FIFO. run_q keeps in_ready low while in reset.
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign occ        = fifo_count + pend_q;
    assign credit     = (occ < CW'(FIFO_DEPTH));
    assign in_ready   = run_q && (state_q != COS) && credit;
    assign accept     = in_valid && in_ready;
    assign push       = tag_vld_q[CALC_LATENCY] && tag_sel_q[CALC_LATENCY];
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid && out_ready;

    assign calc_enable      = calc_en_q;
    assign calc_sine_cosine = calc_sel_q;
    assign calc_theta       = theta_q;
    assign out_cos          = mem_cos_q[rd_ptr_q[AW-1:0]];
    assign out_sin          = mem_sin_q[rd_ptr_q[AW-1:0]];
    assign out_last         = mem_last_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        state_d = state_q;
        theta_d = theta_q;
        last_d  = last_q;
        case (state_q)
            IDLE:    if (accept) state_d = COS;
            COS:     state_d = SIN;
            SIN:     state_d = accept ? COS : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            theta_d = in_theta;
            last_d  = in_last;
        end
        calc_en_d  = (state_d != IDLE);
        calc_sel_d = (state_d == SIN);
    end

    // Tap CALC_LATENCY lines up with calc_value for the request issued that many cycles earlier.
    always_comb begin
        tag_vld_d[1]  = calc_en_q;
        tag_sel_d[1]  = calc_sel_q;
        tag_last_d[1] = last_q;
        for (int i = 2; i <= CALC_LATENCY; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_sel_d[i]  = tag_sel_q[i-1];
            tag_last_d[i] = tag_last_q[i-1];
        end
        cos_d = cos_q;
        if (tag_vld_q[CALC_LATENCY] && !tag_sel_q[CALC_LATENCY]) cos_d = calc_value;
    end

    always_comb begin
        case ({accept, push})
            2'b10:   pend_d = pend_q + CW'(1);
            2'b01:   pend_d = pend_q - CW'(1);
            default: pend_d = pend_q;
        endcase
        wr_ptr_d   = push ? wr_ptr_q + CW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + CW'(1) : rd_ptr_q;
        mem_cos_d  = mem_cos_q;
        mem_sin_d  = mem_sin_q;
        mem_last_d = mem_last_q;
        if (push) begin
            mem_cos_d[wr_ptr_q[AW-1:0]]  = cos_q;
            mem_sin_d[wr_ptr_q[AW-1:0]]  = calc_value;
            mem_last_d[wr_ptr_q[AW-1:0]] = tag_last_q[CALC_LATENCY];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            run_q      <= 1'b0;
            theta_q    <= '0;
            last_q     <= 1'b0;
            calc_en_q  <= 1'b0;
            calc_sel_q <= 1'b0;
            pend_q     <= '0;
            cos_q      <= '0;
            tag_vld_q  <= '0;
            tag_sel_q  <= '0;
            tag_last_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_last_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_cos_q[i] <= '0;
                mem_sin_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            theta_q    <= theta_d;
            last_q     <= last_d;
            calc_en_q  <= calc_en_d;
            calc_sel_q <= calc_sel_d;
            pend_q     <= pend_d;
            cos_q      <= cos_d;
            tag_vld_q  <= tag_vld_d;
            tag_sel_q  <= tag_sel_d;
            tag_last_q <= tag_last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_last_q <= mem_last_d;
            mem_cos_q  <= mem_cos_d;
            mem_sin_q  <= mem_sin_d;
        end
    end

endmodule

// File: tb/tb_sine_request_sequencer.sv
// Directed bench for sine_request_sequencer: fixed-latency calculator model, pair scoreboard,
// plus a second instance built with CALC_LATENCY=4.
module tb_sine_request_sequencer;
    localparam int W     = 32;
    localparam int CL    = 2;
    localparam int CL4   = 4;
    localparam int DEPTH = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, in_last;
    logic [W-1:0] in_theta;
    logic         calc_enable, calc_sine_cosine;
    logic [W-1:0] calc_theta, calc_value;
    logic         out_valid, out_ready, out_last;
    logic [W-1:0] out_cos, out_sin;

    logic         in_valid4, in_ready4, in_last4;
    logic [W-1:0] in_theta4;
    logic         calc_enable4, calc_sine_cosine4;
    logic [W-1:0] calc_theta4, calc_value4;
    logic         out_valid4, out_ready4, out_last4;
    logic [W-1:0] out_cos4, out_sin4;

    sine_request_sequencer #(.CALC_LATENCY(CL), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_theta(in_theta), .in_last(in_last),
        .calc_enable(calc_enable), .calc_theta(calc_theta), .calc_sine_cosine(calc_sine_cosine),
        .calc_value(calc_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_cos(out_cos), .out_sin(out_sin),
        .out_last(out_last)
    );

    sine_request_sequencer #(.CALC_LATENCY(CL4), .FIFO_DEPTH(DEPTH)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_theta(in_theta4), .in_last(in_last4),
        .calc_enable(calc_enable4), .calc_theta(calc_theta4), .calc_sine_cosine(calc_sine_cosine4),
        .calc_value(calc_value4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_cos(out_cos4), .out_sin(out_sin4),
        .out_last(out_last4)
    );

    // calculator model: lookup result holds CALC_LATENCY edges after the request is sampled
    function automatic logic [W-1:0] calc_lut(input logic [W-1:0] th, input logic sel);
        if (th == 32'h3F00_0000) return sel ? 32'h3EF5_7744 : 32'h3F60_A940;
        return sel ? (th ^ 32'h0000_5A5A) : (th ^ 32'h0000_A5A5);
    endfunction

    logic [W-1:0] calc_pipe  [CL];
    logic [W-1:0] calc_pipe4 [CL4];
    always @(posedge clk) begin
        calc_pipe[0] <= calc_enable ? calc_lut(calc_theta, calc_sine_cosine) : 32'hDEAD_BEEF;
        for (int i = 1; i < CL; i++) calc_pipe[i] <= calc_pipe[i-1];
        calc_pipe4[0] <= calc_enable4 ? calc_lut(calc_theta4, calc_sine_cosine4) : 32'hDEAD_BEEF;
        for (int i = 1; i < CL4; i++) calc_pipe4[i] <= calc_pipe4[i-1];
    end
    assign calc_value  = calc_pipe[CL-1];
    assign calc_value4 = calc_pipe4[CL4-1];

    // scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    int pairs_rx = 0;
    logic [W-1:0] exp_cos_q[$];
    logic [W-1:0] exp_sin_q[$];
    logic         exp_last_q[$];

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            check_eq("pair_expected_present", W'(exp_cos_q.size() != 0), W'(1));
            if (exp_cos_q.size() != 0) begin
                check_eq("pair_cos", out_cos, exp_cos_q.pop_front());
                check_eq("pair_sin", out_sin, exp_sin_q.pop_front());
                check_eq("pair_last", W'(out_last), W'(exp_last_q.pop_front()));
            end
            pairs_rx++;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] th, input logic lst);
        exp_cos_q.push_back(calc_lut(th, 1'b0));
        exp_sin_q.push_back(calc_lut(th, 1'b1));
        exp_last_q.push_back(lst);
    endtask

    // called at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic send(input logic [W-1:0] th, input logic lst);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_theta = th;
        in_last  = lst;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_accepted", W'(in_ready), W'(1));
        if (in_ready) push_exp(th, lst);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_pairs(input int target);
        int n;
        n = 0;
        while (pairs_rx < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_eq("pairs_total", W'(pairs_rx), W'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int base;
        in_valid = 1'b0; in_theta = '0; in_last = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_theta4 = '0; in_last4 = 1'b0; out_ready4 = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", W'(in_ready), W'(0));
        check_eq("rst_calc_enable", W'(calc_enable), W'(0));
        check_eq("rst_calc_theta", calc_theta, W'(0));
        check_eq("rst_out_valid", W'(out_valid), W'(0));
        check_eq("rst_out_cos", out_cos, W'(0));
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // single angle, cos/sin of 0.5
        in_valid = 1'b1; in_theta = 32'h3F00_0000; in_last = 1'b1;
        exp_cos_q.push_back(32'h3F60_A940);
        exp_sin_q.push_back(32'h3EF5_7744);
        exp_last_q.push_back(1'b1);
        @(negedge clk);
        check_eq("t1_in_ready_c0", W'(in_ready), W'(1));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_en_c1", W'(calc_enable), W'(1));
        check_eq("t1_sel_c1", W'(calc_sine_cosine), W'(0));
        check_eq("t1_theta_c1", calc_theta, 32'h3F00_0000);
        @(negedge clk);
        check_eq("t1_en_c2", W'(calc_enable), W'(1));
        check_eq("t1_sel_c2", W'(calc_sine_cosine), W'(1));
        @(negedge clk);
        check_eq("t1_en_c3", W'(calc_enable), W'(0));
        check_eq("t1_theta_hold_c3", calc_theta, 32'h3F00_0000);
        @(negedge clk);
        check_eq("t1_out_valid_c4", W'(out_valid), W'(0));
        @(negedge clk);
        check_eq("t1_out_valid_c5", W'(out_valid), W'(1));
        check_eq("t1_out_cos_c5", out_cos, 32'h3F60_A940);
        check_eq("t1_out_sin_c5", out_sin, 32'h3EF5_7744);
        check_eq("t1_out_last_c5", W'(out_last), W'(1));
        tick();

        // back-to-back: 8 angles with in_valid held
        base = pairs_rx;
        idx = 0;
        in_valid = 1'b1; in_theta = 32'h4010_0000; in_last = 1'b0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k <= 14) check_eq($sformatf("b2b_in_ready_k%0d", k), W'(in_ready), W'(k % 2 == 0));
            check_eq($sformatf("b2b_calc_enable_k%0d", k), W'(calc_enable), W'(k >= 1 && k <= 16));
            if (in_valid && in_ready) begin
                push_exp(in_theta, in_last);
                idx++;
            end
            tick();
            if (idx == 8) in_valid = 1'b0;
            else begin
                in_theta = 32'h4010_0000 + idx * 32'h0001_1000;
                in_last  = (idx == 7);
            end
        end
        wait_pairs(base + 8);
        tick();

        // backpressure: 10 angles offered with out_ready low
        base = pairs_rx;
        idx = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_theta = 32'h4100_0000; in_last = 1'b0;
        for (int k = 0; k < 150 && idx < 10; k++) begin
            @(negedge clk);
            if (k == 25 || k == 29) begin
                check_eq("bp_accepted", W'(idx), W'(DEPTH));
                check_eq("bp_in_ready_low", W'(in_ready), W'(0));
                check_eq("bp_out_valid", W'(out_valid), W'(1));
                check_eq("bp_head_cos_stable", out_cos, exp_cos_q[0]);
                check_eq("bp_head_sin_stable", out_sin, exp_sin_q[0]);
            end
            if (in_valid && in_ready) begin
                push_exp(in_theta, in_last);
                idx++;
            end
            tick();
            if (k == 29) out_ready = 1'b1;
            if (idx == 10) in_valid = 1'b0;
            else begin
                in_theta = 32'h4100_0000 + idx * 32'h0000_0100;
                in_last  = (idx == 9);
            end
        end
        in_valid = 1'b0;
        check_eq("bp_all_accepted", W'(idx), W'(10));
        wait_pairs(base + 10);
        tick();

        // simultaneous pop and accept with three pairs in the FIFO
        base = pairs_rx;
        out_ready = 1'b0;
        send(32'h4200_0001, 1'b0);
        send(32'h4200_0002, 1'b0);
        send(32'h4200_0003, 1'b0);
        repeat (8) tick();
        in_valid = 1'b1; in_theta = 32'h4200_0004; in_last = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("pa_out_valid_c0", W'(out_valid), W'(1));
        check_eq("pa_in_ready_occ3_c0", W'(in_ready), W'(1));
        if (in_ready) push_exp(in_theta, in_last);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("pa_in_ready_cos_c1", W'(in_ready), W'(0));
        tick();
        in_valid = 1'b1; in_theta = 32'h4200_0005; in_last = 1'b1;
        @(negedge clk);
        check_eq("pa_in_ready_occ3_c2", W'(in_ready), W'(1));
        if (in_ready) push_exp(in_theta, in_last);
        tick();
        in_valid = 1'b1; in_theta = 32'h4200_0006;
        @(negedge clk);
        @(negedge clk);
        check_eq("pa_no_credit_c4", W'(in_ready), W'(0));
        repeat (5) @(negedge clk);
        check_eq("pa_no_credit_c9", W'(in_ready), W'(0));
        check_eq("pa_head_cos", out_cos, exp_cos_q[0]);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_pairs(base + 5);
        tick();

        // reset mid-operation: one pair in the FIFO, two in flight
        base = pairs_rx;
        out_ready = 1'b0;
        send(32'h4300_0001, 1'b0);
        send(32'h4300_0002, 1'b0);
        send(32'h4300_0003, 1'b0);
        check_eq("rm_pre_out_valid", W'(out_valid), W'(1));
        rst_n = 1'b0;
        #1;
        check_eq("rm_out_valid", W'(out_valid), W'(0));
        check_eq("rm_out_cos", out_cos, W'(0));
        check_eq("rm_out_sin", out_sin, W'(0));
        check_eq("rm_calc_enable", W'(calc_enable), W'(0));
        check_eq("rm_calc_theta", calc_theta, W'(0));
        check_eq("rm_in_ready", W'(in_ready), W'(0));
        exp_cos_q.delete();
        exp_sin_q.delete();
        exp_last_q.delete();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (20) tick();
        check_eq("rm_no_stale_pair", W'(pairs_rx), W'(base));
        send(32'h3F00_0000, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("rm_out_valid_c4", W'(out_valid), W'(0));
        @(negedge clk);
        check_eq("rm_out_valid_c5", W'(out_valid), W'(1));
        check_eq("rm_out_cos_c5", out_cos, 32'h3F60_A940);
        check_eq("rm_out_sin_c5", out_sin, 32'h3EF5_7744);
        tick();
        repeat (3) tick();

        // CALC_LATENCY=4 instance: single angle
        in_valid4 = 1'b1; in_theta4 = 32'h3F00_0000; in_last4 = 1'b1;
        @(negedge clk);
        check_eq("l4_in_ready_c0", W'(in_ready4), W'(1));
        tick();
        in_valid4 = 1'b0;
        @(negedge clk);
        check_eq("l4_en_c1", W'(calc_enable4), W'(1));
        check_eq("l4_sel_c1", W'(calc_sine_cosine4), W'(0));
        @(negedge clk);
        check_eq("l4_sel_c2", W'(calc_sine_cosine4), W'(1));
        repeat (4) @(negedge clk);
        check_eq("l4_out_valid_c6", W'(out_valid4), W'(0));
        @(negedge clk);
        check_eq("l4_out_valid_c7", W'(out_valid4), W'(1));
        check_eq("l4_out_cos_c7", out_cos4, 32'h3F60_A940);
        check_eq("l4_out_sin_c7", out_sin4, 32'h3EF5_7744);
        check_eq("l4_out_last_c7", W'(out_last4), W'(1));
        @(negedge clk);
        check_eq("l4_popped_c8", W'(out_valid4), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
